axi_stream_arbiter: RTL and testbench

Packet-level round-robin arbiter that shares one AXI4-Stream master channel among `N_PORTS` AXI4-Stream slave channels. It sits between several stream sources (for example, packet generators of the fixed-length burst type) and a single downstream consumer. A granted source is locked until its `tlast` beat completes, so packets are never interleaved. Once locked, the data path is combinational pass-through with zero added latency.

---
 rtl/axi_stream_arbiter.sv | 133 +++++++++++++
 tb/tb_axi_stream_arbiter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_stream_arbiter.sv
// axi_stream_arbiter
//   Packet-level round-robin arbiter. Merges N_PORTS AXI4-Stream slave channels onto a single
//   master channel. A grant is held until the granted source's tlast beat completes, so packets
//   never interleave. While a grant is held, the data path is a zero-latency pass-through.
//
// Ports
//   aclk, areset_n    clock and asynchronous active-low reset
//   s_tvalid/s_tready per-source handshake (N_PORTS bits each)
//   s_tlast, s_tdata  per-source last flag and data (s_tdata packed, index = port)
//   m_tvalid/m_tready downstream handshake
//   m_tlast, m_tdata  downstream last flag and data
//   m_tid             granted port index (0 while idle)
//   busy              a grant is held
//   pkt_cnt           completed packets on the master side (wraps at 16 bits)
module axi_stream_arbiter #(
  parameter int unsigned N_PORTS = 4,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ID_W    = $clog2(N_PORTS)
) (
  input  logic                           aclk,
  input  logic                           areset_n,
  input  logic [N_PORTS-1:0]             s_tvalid,
  output logic [N_PORTS-1:0]             s_tready,
  input  logic [N_PORTS-1:0]             s_tlast,
  input  logic [N_PORTS-1:0][DATA_W-1:0] s_tdata,
  output logic                           m_tvalid,
  input  logic                           m_tready,
  output logic                           m_tlast,
  output logic [DATA_W-1:0]              m_tdata,
  output logic [ID_W-1:0]                m_tid,
  output logic                           busy,
  output logic [15:0]                    pkt_cnt
);

  typedef enum logic {StIdle, StLock} state_e;

  state_e            state_q, state_d;
  logic [ID_W-1:0]   grant_q, grant_d;
  logic [ID_W-1:0]   last_grant_q, last_grant_d;
  logic [15:0]       pkt_cnt_q, pkt_cnt_d;

  logic [N_PORTS-1:0] grant_oh;
  logic [N_PORTS-1:0] req;
  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    scan_idx;
  logic [ID_W-1:0]    pick_idx;
  logic               pick_vld;
  logic               pkt_end;

  assign grant_oh = N_PORTS'(1) << grant_q;

  // Data path: pure pass-through of the granted source while locked.
  always_comb begin
    s_tready = '0;
    m_tvalid = 1'b0;
    m_tlast  = 1'b0;
    m_tdata  = '0;
    m_tid    = '0;
    if (state_q == StLock) begin
      m_tvalid          = s_tvalid[grant_q];
      m_tlast           = s_tlast[grant_q];
      m_tdata           = s_tdata[grant_q];
      m_tid             = grant_q;
      s_tready[grant_q] = m_tready;
    end
  end

  assign pkt_end = (state_q == StLock) && m_tvalid && m_tready && m_tlast;
  assign busy    = (state_q == StLock);
  assign pkt_cnt = pkt_cnt_q;

  // At a packet end the pointer is the finishing port, i.e. the value last_grant takes on this
  // edge, so the re-arbitration already scans from the port after it. The finishing port is
  // masked for this one decision so another requester always wins if present.
  assign req    = (state_q == StLock) ? (s_tvalid & ~grant_oh) : s_tvalid;
  assign rr_ptr = (state_q == StLock) ? grant_q : last_grant_q;

  // Round-robin scan: rr_ptr+1, rr_ptr+2, ... modulo N_PORTS; first set request wins.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    scan_idx = '0;
    for (int unsigned i = 1; i <= N_PORTS; i++) begin
      scan_idx = ID_W'((32'(rr_ptr) + i) % N_PORTS);
      if (!pick_vld && req[scan_idx]) begin
        pick_vld = 1'b1;
        pick_idx = scan_idx;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    pkt_cnt_d    = pkt_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (pick_vld) begin
          grant_d = pick_idx;
          state_d = StLock;
        end
      end
      StLock: begin
        if (pkt_end) begin
          last_grant_d = grant_q;
          pkt_cnt_d    = pkt_cnt_q + 16'd1;
          if (pick_vld) begin
            grant_d = pick_idx;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      state_q      <= StIdle;
      grant_q      <= '0;
      last_grant_q <= ID_W'(N_PORTS - 1);
      pkt_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      pkt_cnt_q    <= pkt_cnt_d;
    end
  end

endmodule

// File: tb/tb_axi_stream_arbiter.sv
// Directed bench for axi_stream_arbiter: behavioural sources, scoreboard of expected master
// beats in grant order, and point checks on control outputs.
module tb_axi_stream_arbiter;

  localparam int NP = 4;
  localparam int DW = 32;
  localparam int IW = 2;

  logic                   aclk = 1'b0;
  logic                   areset_n;
  logic [NP-1:0]          s_tvalid;
  logic [NP-1:0]          s_tready;
  logic [NP-1:0]          s_tlast;
  logic [NP-1:0][DW-1:0]  s_tdata;
  logic                   m_tvalid;
  logic                   m_tready;
  logic                   m_tlast;
  logic [DW-1:0]          m_tdata;
  logic [IW-1:0]          m_tid;
  logic                   busy;
  logic [15:0]            pkt_cnt;

  axi_stream_arbiter #(
    .N_PORTS (NP),
    .DATA_W  (DW),
    .ID_W    (IW)
  ) dut (
    .aclk     (aclk),
    .areset_n (areset_n),
    .s_tvalid (s_tvalid),
    .s_tready (s_tready),
    .s_tlast  (s_tlast),
    .s_tdata  (s_tdata),
    .m_tvalid (m_tvalid),
    .m_tready (m_tready),
    .m_tlast  (m_tlast),
    .m_tdata  (m_tdata),
    .m_tid    (m_tid),
    .busy     (busy),
    .pkt_cnt  (pkt_cnt)
  );

  always #5 aclk = ~aclk;

  typedef struct packed {
    logic [IW-1:0] tid;
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  beat_t sb[$];
  int    checks = 0;
  int    errors = 0;

  // Source model: each port emits left[p] beats, data = base + beat index, tlast every plen beats.
  int            left [NP];
  int            sent [NP];
  int            plen [NP];
  logic [DW-1:0] base [NP];
  bit            stall[NP];

  always_comb begin
    for (int p = 0; p < NP; p++) begin
      s_tvalid[p] = (left[p] > 0) && !stall[p];
      s_tdata[p]  = base[p] + DW'(sent[p]);
      s_tlast[p]  = (plen[p] > 0) && ((sent[p] % plen[p]) == plen[p] - 1);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start(input int p, input int npk, input int len, input logic [DW-1:0] b0);
    plen[p] = len;
    base[p] = b0;
    sent[p] = 0;
    left[p] = npk * len;
  endtask

  task automatic push_pkt(input int p, input int pk);
    beat_t b;
    for (int i = 0; i < plen[p]; i++) begin
      b.tid  = IW'(p);
      b.data = base[p] + DW'(pk * plen[p] + i);
      b.last = (i == plen[p] - 1);
      sb.push_back(b);
    end
  endtask

  // One clock: sample mid-cycle, check any master handshake against the scoreboard, advance
  // sources that handshook at the edge, return at the next falling edge.
  task automatic cyc();
    logic [NP-1:0] hs;
    beat_t         got;
    beat_t         exp;
    #1;
    hs = s_tvalid & s_tready;
    if (m_tvalid && m_tready) begin
      got.tid  = m_tid;
      got.data = m_tdata;
      got.last = m_tlast;
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL sb_extra: observed beat %0h expected no beat", got);
      end
      if (sb.size() != 0) begin
        exp = sb.pop_front();
        chk("beat", 64'(got), 64'(exp));
      end
    end
    @(posedge aclk);
    #1;
    for (int p = 0; p < NP; p++) begin
      if (hs[p]) begin
        sent[p]++;
        left[p]--;
      end
    end
    @(negedge aclk);
  endtask

  initial begin
    areset_n = 1'b0;
    m_tready = 1'b1;
    for (int p = 0; p < NP; p++) begin
      left[p]  = 0;
      sent[p]  = 0;
      plen[p]  = 1;
      base[p]  = '0;
      stall[p] = 1'b0;
    end
    repeat (2) @(negedge aclk);
    #1;
    chk("rst_m_tvalid", 64'(m_tvalid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
    chk("rst_m_tid", 64'(m_tid), 64'd0);
    chk("rst_s_tready", 64'(s_tready), 64'd0);
    @(negedge aclk);
    areset_n = 1'b1;

    // All four ports at once: grants 0,1,2,3 back-to-back.
    for (int p = 0; p < NP; p++) start(p, 1, 3, DW'(32'h10 * (p + 1)));
    for (int p = 0; p < NP; p++) push_pkt(p, 0);
    #1;
    chk("all_not_comb", 64'(m_tvalid), 64'd0);
    cyc();
    chk("all_first_tid", 64'(m_tid), 64'd0);
    repeat (12) cyc();
    chk("all_sb_empty", 64'(sb.size()), 64'd0);
    chk("all_pkt_cnt", 64'(pkt_cnt), 64'd4);
    chk("all_idle", 64'(busy), 64'd0);

    // Fairness: ports 0 and 3 with three 2-beat packets each must alternate 0,3,0,3,0,3.
    start(0, 3, 2, 32'h100);
    start(3, 3, 2, 32'h400);
    for (int k = 0; k < 3; k++) begin
      push_pkt(0, k);
      push_pkt(3, k);
    end
    cyc();
    repeat (12) cyc();
    chk("fair_sb_empty", 64'(sb.size()), 64'd0);
    chk("fair_pkt_cnt", 64'(pkt_cnt), 64'd10);

    // Single source: port 2, beats 0xA0..0xA3.
    start(2, 1, 4, 32'hA0);
    push_pkt(2, 0);
    #1;
    chk("single_not_comb", 64'(m_tvalid), 64'd0);
    cyc();
    chk("single_m_tvalid", 64'(m_tvalid), 64'd1);
    chk("single_m_tid", 64'(m_tid), 64'd2);
    chk("single_busy", 64'(busy), 64'd1);
    chk("single_m_tdata", 64'(m_tdata), 64'hA0);
    repeat (4) cyc();
    chk("single_pkt_cnt", 64'(pkt_cnt), 64'd11);
    chk("single_idle", 64'(busy), 64'd0);
    chk("single_sb_empty", 64'(sb.size()), 64'd0);

    // Backpressure on port 1: m_tready 1,0,0,1.
    start(1, 1, 4, 32'hB0);
    push_pkt(1, 0);
    cyc();
    m_tready = 1'b1;
    #1;
    chk("bp_ready1", 64'(s_tready), 64'b0010);
    cyc();
    for (int k = 0; k < 2; k++) begin
      m_tready = 1'b0;
      #1;
      chk("bp_ready0", 64'(s_tready), 64'b0000);
      chk("bp_hold_data", 64'(m_tdata), 64'hB1);
      chk("bp_hold_valid", 64'(m_tvalid), 64'd1);
      cyc();
    end
    m_tready = 1'b1;
    #1;
    chk("bp_ready_back", 64'(s_tready), 64'b0010);
    repeat (3) cyc();
    chk("bp_pkt_cnt", 64'(pkt_cnt), 64'd12);
    chk("bp_sb_empty", 64'(sb.size()), 64'd0);

    // Source stall: port 3 pauses 3 cycles mid-packet while port 1 waits.
    start(3, 1, 4, 32'hC0);
    push_pkt(3, 0);
    cyc();
    chk("stall_tid", 64'(m_tid), 64'd3);
    start(1, 1, 2, 32'hD0);
    push_pkt(1, 0);
    cyc();
    stall[3] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("stall_m_tvalid", 64'(m_tvalid), 64'd0);
      chk("stall_held_tid", 64'(m_tid), 64'd3);
      chk("stall_s_tready", 64'(s_tready), 64'b1000);
      cyc();
    end
    stall[3] = 1'b0;
    repeat (5) cyc();
    chk("stall_sb_empty", 64'(sb.size()), 64'd0);
    chk("stall_pkt_cnt", 64'(pkt_cnt), 64'd14);
    chk("stall_idle", 64'(busy), 64'd0);

    // Reset during beat 2 of a port-1 packet.
    start(1, 1, 4, 32'hE0);
    push_pkt(1, 0);
    repeat (3) cyc();
    chk("rstmid_beat2", 64'(m_tdata), 64'hE2);
    areset_n = 1'b0;
    #1;
    chk("rstmid_m_tvalid", 64'(m_tvalid), 64'd0);
    chk("rstmid_busy", 64'(busy), 64'd0);
    chk("rstmid_pkt_cnt", 64'(pkt_cnt), 64'd0);
    chk("rstmid_s_tready", 64'(s_tready), 64'd0);
    left[1] = 0;
    sb.delete();
    cyc();
    start(0, 1, 1, 32'hF0);
    start(1, 1, 1, 32'hF8);
    push_pkt(0, 0);
    push_pkt(1, 0);
    areset_n = 1'b1;
    cyc();
    chk("rstmid_first_tid", 64'(m_tid), 64'd0);
    repeat (3) cyc();
    chk("rstmid_sb_empty", 64'(sb.size()), 64'd0);
    chk("rstmid_pkt_cnt2", 64'(pkt_cnt), 64'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
